// File: rtl/block_pe_gen.sv
// Elastic CGRA processing element: NUM_IN channels, one configurable
// ALU, feedback register and DEPTH-entry output FIFO.
module block_pe_gen #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int DEPTH  = 4,
  localparam int SEL_W = $clog2(NUM_IN + 1),
  localparam int CFG_W = 2 * SEL_W + 3,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    config_en,
  input  logic                    config_in,
  output logic                    config_out,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out0,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CW-1:0]           fifo_count
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SH_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SHL = 3'd6,
    OP_ACC = 3'd7
  } op_e;

  logic [CFG_W-1:0] cfg;
  logic [SEL_W-1:0] src_a;
  logic [SEL_W-1:0] src_b;
  op_e              op;
  logic [WIDTH-1:0] fb;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             va;
  logic             vb;
  logic [WIDTH-1:0] res;
  logic             is_acc;
  logic             pop;
  logic             space;
  logic             fire;

  assign src_a      = cfg[SEL_W-1:0];
  assign src_b      = cfg[2*SEL_W-1:SEL_W];
  assign op         = op_e'(cfg[CFG_W-1 -: 3]);
  assign is_acc     = (op == OP_ACC);
  assign config_out = cfg[0];
  assign out_valid  = (fifo_count != '0);
  assign out0       = mem[rd_ptr];
  assign pop        = out_valid && out_ready;
  assign space      = (fifo_count < CW'(DEPTH)) || pop;

  // Codes at or beyond NUM_IN fall through to fb, always valid.
  always_comb begin
    a  = fb;
    b  = fb;
    va = 1'b1;
    vb = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (src_a == SEL_W'(i)) begin
        a  = in_data[i*WIDTH +: WIDTH];
        va = in_valid[i];
      end
      if (src_b == SEL_W'(i)) begin
        b  = in_data[i*WIDTH +: WIDTH];
        vb = in_valid[i];
      end
    end
  end

  always_comb begin
    res = '0;
    unique case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_MUL:  res = a * b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SHL:  res = a << b[SH_W-1:0];
      OP_ACC:  res = fb + a;
      default: res = '0;
    endcase
  end

  // Gating on reset keeps in_ready low while reset is held.
  assign fire = reset && !config_en && va &&
                (is_acc || vb) && space;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = fire &&
        ((src_a == SEL_W'(i)) ||
         (!is_acc && src_b == SEL_W'(i)));
    end
  end

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg        <= '0;
      fb         <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (config_en) begin
        cfg <= {config_in, cfg[CFG_W-1:1]};
      end
      if (fire) begin
        mem[wr_ptr] <= res;
        wr_ptr      <= inc(wr_ptr);
        fb          <= res;
      end
      if (pop) begin
        rd_ptr <= inc(rd_ptr);
      end
      if (fire && !pop) begin
        fifo_count <= fifo_count + CW'(1);
      end else if (!fire && pop) begin
        fifo_count <= fifo_count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_block_pe_gen.sv
// Directed testbench for block_pe_gen (WIDTH=32, NUM_IN=4, DEPTH=4).
module tb_block_pe_gen;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 4;
  localparam int DEPTH  = 4;
  localparam int CFG_W  = 9;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    config_en = 1'b0;
  logic                    config_in = 1'b0;
  logic                    config_out;
  logic [NUM_IN*WIDTH-1:0] in_data = '0;
  logic [NUM_IN-1:0]       in_valid = '0;
  logic [NUM_IN-1:0]       in_ready;
  logic [WIDTH-1:0]        out0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [2:0]              fifo_count;

  int checks = 0;
  int errors = 0;

  block_pe_gen #(
    .WIDTH(WIDTH), .NUM_IN(NUM_IN), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .config_en(config_en), .config_in(config_in),
    .config_out(config_out),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out0(out0),
    .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] cw(
    input logic [2:0] op, input logic [2:0] sb,
    input logic [2:0] sa
  );
    return {op, sb, sa};
  endfunction

  task automatic set_ch(input int i, input logic [31:0] v);
    in_data[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [8:0] w);
    config_en = 1'b1;
    for (int i = 0; i < CFG_W; i++) begin
      config_in = w[i];
      tick();
    end
    config_en = 1'b0;
    config_in = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = '0;
    for (int i = 0; i < 20 && fifo_count != 0; i++) tick();
    checks++;
    if (fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL drain: count %0d want 0", fifo_count);
    end
  endtask

  task automatic do_fire(
    input logic [31:0] va, input logic [31:0] vb,
    output logic [31:0] r
  );
    set_ch(0, va);
    set_ch(1, vb);
    in_valid  = 4'b0011;
    out_ready = 1'b0;
    tick();
    r = out0;
    in_valid  = '0;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    in_valid = 4'b0001;
    #3;
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_fifo: valid %b count %0d want 0 0",
               out_valid, fifo_count);
    end
    checks++;
    if (in_ready !== 4'b0000 || config_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: rdy %b cfgout %b want 0000 0",
               in_ready, config_out);
    end
    in_valid = '0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    tick();
  endtask

  task automatic test_acc();
    logic [31:0] exp [3] = '{32'd1, 32'd3, 32'd6};
    load_cfg(cw(3'd7, 3'd1, 3'd0));
    for (int i = 0; i < NUM_IN; i++) set_ch(i, 32'd9);
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_ch(0, 32'(k + 1));
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin
        errors++;
        $display("FAIL acc_ready%0d: got %b want 0001",
                 k, in_ready);
      end
      tick();
      checks++;
      if (out0 !== exp[k] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL acc_out%0d: got %0d v%b want %0d",
                 k, out0, out_valid, exp[k]);
      end
    end
    drain();
  endtask

  task automatic test_basic_add();
    load_cfg(cw(3'd0, 3'd1, 3'd0));
    set_ch(0, 32'd5);
    set_ch(1, 32'd7);
    in_valid  = 4'b0011;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0011) begin
      errors++;
      $display("FAIL add_ready: got %b want 0011", in_ready);
    end
    tick();
    in_valid = '0;
    checks++;
    if (out0 !== 32'd12 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL add_out: got %0d v%b want 12 v1",
               out0, out_valid);
    end
    drain();
  endtask

  task automatic test_full_fifo();
    out_ready = 1'b0;
    set_ch(1, 32'd100);
    in_valid = 4'b0011;
    for (int k = 1; k <= 4; k++) begin
      set_ch(0, 32'(k));
      #1;
      checks++;
      if (in_ready !== 4'b0011) begin
        errors++;
        $display("FAIL fill_ready%0d: got %b want 0011",
                 k, in_ready);
      end
      tick();
    end
    #1;
    checks++;
    if (in_ready !== 4'b0000 || fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL full_stall: rdy %b count %0d want 0000 4",
               in_ready, fifo_count);
    end
    out_ready = 1'b1;
    set_ch(0, 32'd5);
    #1;
    checks++;
    if (in_ready !== 4'b0011 || out0 !== 32'd101) begin
      errors++;
      $display("FAIL full_pushpop: rdy %b out %0d want 0011 101",
               in_ready, out0);
    end
    tick();
    in_valid = '0;
    checks++;
    if (fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL full_count: got %0d want 4", fifo_count);
    end
    for (int e = 102; e <= 105; e++) begin
      checks++;
      if (out0 !== 32'(e)) begin
        errors++;
        $display("FAIL full_order: got %0d want %0d", out0, e);
      end
      tick();
    end
    checks++;
    if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_empty: count %0d v%b want 0 v0",
               fifo_count, out_valid);
    end
  endtask

  task automatic test_wrap();
    logic [2:0]  ops [6] = '{3'd1, 3'd2, 3'd6, 3'd3, 3'd4, 3'd5};
    logic [31:0] av  [6] = '{32'd3, 32'h0001_0000, 32'd1,
                             32'hF0F0, 32'hF0F0, 32'hF0F0};
    logic [31:0] bv  [6] = '{32'd5, 32'h0001_0000, 32'd33,
                             32'hFF00, 32'h0F0F, 32'hFF00};
    logic [31:0] ev  [6] = '{32'hFFFF_FFFE, 32'h0, 32'h2,
                             32'hF000, 32'hFFFF, 32'h0FF0};
    logic [31:0] r;
    for (int k = 0; k < 6; k++) begin
      load_cfg(cw(ops[k], 3'd1, 3'd0));
      do_fire(av[k], bv[k], r);
      checks++;
      if (r !== ev[k]) begin
        errors++;
        $display("FAIL alu_op%0d: got %h want %h",
                 ops[k], r, ev[k]);
      end
    end
  endtask

  task automatic test_config_freeze();
    logic [8:0]  p = 9'b101100110;
    logic [8:0]  w;
    logic [17:0] seq;
    w   = cw(3'd7, 3'd1, 3'd0);
    seq = {w, p};
    load_cfg(cw(3'd0, 3'd1, 3'd0));
    out_ready = 1'b0;
    in_valid  = 4'b0011;
    set_ch(0, 32'd10);
    set_ch(1, 32'd1);
    tick();
    set_ch(0, 32'd20);
    set_ch(1, 32'd2);
    tick();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    config_en = 1'b1;
    for (int k = 0; k < 18; k++) begin
      config_in = seq[k];
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL frz_ready%0d: got %b want 0000",
                 k, in_ready);
      end
      if (k == 0) begin
        checks++;
        if (out0 !== 32'd11 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL frz_pop0: got %0d want 11", out0);
        end
      end
      if (k == 1) begin
        checks++;
        if (out0 !== 32'd22 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL frz_pop1: got %0d want 22", out0);
        end
      end
      if (k == 2) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL frz_drained: got v%b want v0",
                   out_valid);
        end
      end
      if (k >= 9) begin
        checks++;
        if (config_out !== seq[k-9]) begin
          errors++;
          $display("FAIL cfg_replay%0d: got %b want %b",
                   k, config_out, seq[k-9]);
        end
      end
      tick();
    end
    config_en = 1'b0;
    config_in = 1'b0;
    set_ch(0, 32'd1);
    in_valid = 4'b0001;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL frz_resume: got %b want 0001", in_ready);
    end
    tick();
    in_valid = '0;
    checks++;
    if (out0 !== 32'd23) begin
      errors++;
      $display("FAIL frz_fb_hold: got %0d want 23", out0);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    load_cfg(cw(3'd0, 3'd1, 3'd0));
    out_ready = 1'b0;
    in_valid  = 4'b0011;
    set_ch(1, 32'd5);
    set_ch(0, 32'h10);
    tick();
    set_ch(0, 32'h20);
    tick();
    set_ch(0, 32'h50);
    tick();
    in_valid = '0;
    checks++;
    if (fifo_count !== 3'd3) begin
      errors++;
      $display("FAIL rst_pre: count %0d want 3", fifo_count);
    end
    #2;
    reset    = 1'b0;
    in_valid = 4'b0011;
    #1;
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL rst_async: v%b count %0d want v0 0",
               out_valid, fifo_count);
    end
    checks++;
    if (dut.fb !== 32'h0 || dut.cfg !== 9'h0) begin
      errors++;
      $display("FAIL rst_state: fb %h cfg %h want 0 0",
               dut.fb, dut.cfg);
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rst_ready: got %b want 0000", in_ready);
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    set_ch(0, 32'd4);
    in_valid = 4'b0001;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rst_fire_rdy: got %b want 0001", in_ready);
    end
    tick();
    in_valid = '0;
    checks++;
    if (out0 !== 32'd8 || fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL rst_default_add: got %0d c%0d want 8 c1",
               out0, fifo_count);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_acc();
    test_basic_add();
    test_full_fifo();
    test_wrap();
    test_config_freeze();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
